// File: rtl/ram64_wave_reader.sv
// ram64_wave_reader: access-side controller for the 64 x 20-bit wavetable RAM.
// Host writes go to the RAM through a valid/ready port. Each enabled sample_tick
// reads the table at the phase-accumulator index and presents the sample
// downstream on a valid/ready port.
// Optional feature: define WAVE_LINEAR_INTERP_EN for linear interpolation
// between adjacent entries (adds RD_B and CALC states).
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | wait for a tick (priority) or a host write
// WRITE  | ram_load high for exactly one cycle
// RD_A   | ram_out is entry[idx]; capture it
// RD_B   | (interp) ram_out is entry[idx+1]; capture it
// CALC   | (interp) blend the two entries with the phase fraction
// VALID  | sample presented, held until smp_ready
module ram64_wave_reader #(
    parameter int DATA_W  = 20,
    parameter int ADDR_W  = 6,
    parameter int PHASE_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [PHASE_W-1:0] phase_inc,
    input  logic               sample_tick,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0]  wr_data,
    output logic               ram_load,
    output logic [DATA_W-1:0]  ram_in,
    output logic [ADDR_W-1:0]  ram_sel,
    input  logic [DATA_W-1:0]  ram_out,
    output logic [DATA_W-1:0]  smp_data,
    output logic               smp_valid,
    input  logic               smp_ready,
    output logic               overrun
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_RD_A  = 3'd2;
`ifdef WAVE_LINEAR_INTERP_EN
    localparam logic [2:0] S_RD_B  = 3'd3;
    localparam logic [2:0] S_CALC  = 3'd4;
    localparam int         PROD_W  = DATA_W + 5;
`endif
    localparam logic [2:0] S_VALID = 3'd5;

    logic [2:0]         state_q, state_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               tick_pending_q, tick_pending_d;
    logic [ADDR_W-1:0]  ram_sel_q, ram_sel_d;
    logic [DATA_W-1:0]  ram_in_q, ram_in_d;
    logic [DATA_W-1:0]  smp_data_q, smp_data_d;
    logic               overrun_q, overrun_d;

    logic [ADDR_W-1:0]  idx;
    logic               start_rd;
    logic               wr_ready_c;

`ifdef WAVE_LINEAR_INTERP_EN
    logic [DATA_W-1:0]        a_q, a_d;
    logic [DATA_W-1:0]        b_q, b_d;
    logic [3:0]               frac;
    logic signed [DATA_W:0]   diff;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] shifted;
    logic                     interp_unused;

    // Blend: a + ((b - a) * frac) >>> 4; the 21-bit difference cannot overflow.
    always_comb begin
        frac    = phase_q[PHASE_W-ADDR_W-1 -: 4];
        diff    = $signed({b_q[DATA_W-1], b_q}) - $signed({a_q[DATA_W-1], a_q});
        prod    = PROD_W'(diff) * PROD_W'($signed({1'b0, frac}));
        shifted = prod >>> 4;
    end
    assign interp_unused = ^shifted[PROD_W-1:DATA_W];
`endif

    assign idx        = phase_q[PHASE_W-1 -: ADDR_W];
    assign start_rd   = (state_q == S_IDLE) && enable && (tick_pending_q || sample_tick);
    assign wr_ready_c = rst_n && (state_q == S_IDLE) && !start_rd;

    // Next-state, tick bookkeeping and datapath updates.
    always_comb begin
        state_d        = state_q;
        phase_d        = phase_q;
        ram_sel_d      = ram_sel_q;
        ram_in_d       = ram_in_q;
        smp_data_d     = smp_data_q;
        overrun_d      = enable && sample_tick && tick_pending_q;
        tick_pending_d = tick_pending_q;
`ifdef WAVE_LINEAR_INTERP_EN
        a_d            = a_q;
        b_d            = b_q;
`endif
        if (start_rd) begin
            tick_pending_d = 1'b0;
        end else if (enable && sample_tick) begin
            tick_pending_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start_rd) begin
                    state_d   = S_RD_A;
                    ram_sel_d = idx;
                end else if (wr_valid && wr_ready_c) begin
                    state_d   = S_WRITE;
                    ram_sel_d = wr_addr;
                    ram_in_d  = wr_data;
                end
            end
            S_WRITE: state_d = S_IDLE;
            S_RD_A: begin
`ifdef WAVE_LINEAR_INTERP_EN
                a_d       = ram_out;
                ram_sel_d = idx + ADDR_W'(1);
                state_d   = S_RD_B;
`else
                smp_data_d = ram_out;
                phase_d    = phase_q + phase_inc;
                state_d    = S_VALID;
`endif
            end
`ifdef WAVE_LINEAR_INTERP_EN
            S_RD_B: begin
                b_d     = ram_out;
                state_d = S_CALC;
            end
            S_CALC: begin
                smp_data_d = a_q + shifted[DATA_W-1:0];
                phase_d    = phase_q + phase_inc;
                state_d    = S_VALID;
            end
`endif
            S_VALID: begin
                if (smp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Register update with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            phase_q        <= '0;
            tick_pending_q <= 1'b0;
            ram_sel_q      <= '0;
            ram_in_q       <= '0;
            smp_data_q     <= '0;
            overrun_q      <= 1'b0;
`ifdef WAVE_LINEAR_INTERP_EN
            a_q            <= '0;
            b_q            <= '0;
`endif
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            tick_pending_q <= tick_pending_d;
            ram_sel_q      <= ram_sel_d;
            ram_in_q       <= ram_in_d;
            smp_data_q     <= smp_data_d;
            overrun_q      <= overrun_d;
`ifdef WAVE_LINEAR_INTERP_EN
            a_q            <= a_d;
            b_q            <= b_d;
`endif
        end
    end

    assign wr_ready  = wr_ready_c;
    assign ram_load  = (state_q == S_WRITE);
    assign ram_in    = ram_in_q;
    assign ram_sel   = ram_sel_q;
    assign smp_data  = smp_data_q;
    assign smp_valid = (state_q == S_VALID);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_ram64_wave_reader.sv
// Testbench for ram64_wave_reader: behavioural RAM64 plus a table/phase
// reference model computed directly from the sample rules.
module tb_ram64_wave_reader;

    localparam int DW = 20;
    localparam int AW = 6;
    localparam int PW = 16;
`ifdef WAVE_LINEAR_INTERP_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic          clk;
    logic          rst_n;
    logic          enable;
    logic [PW-1:0] phase_inc;
    logic          sample_tick;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          ram_load;
    logic [DW-1:0] ram_in;
    logic [AW-1:0] ram_sel;
    logic [DW-1:0] ram_out;
    logic [DW-1:0] smp_data;
    logic          smp_valid;
    logic          smp_ready;
    logic          overrun;

    ram64_wave_reader dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .phase_inc(phase_inc),
        .sample_tick(sample_tick), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .ram_load(ram_load),
        .ram_in(ram_in), .ram_sel(ram_sel), .ram_out(ram_out),
        .smp_data(smp_data), .smp_valid(smp_valid), .smp_ready(smp_ready),
        .overrun(overrun)
    );

    // Behavioural RAM64: combinational read, write on LOAD at the clock edge.
    logic [DW-1:0] mem [64];
    assign ram_out = mem[ram_sel];
    always @(posedge clk) if (ram_load) mem[ram_sel] <= ram_in;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state.
    logic [DW-1:0] tab [64];
    int            phase_m;
    int            inc_m;
    logic [DW-1:0] last_data;

    int total;
    int passed;
    int failed;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else begin
            failed = failed + 1;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int sx(input logic [DW-1:0] v);
        return int'($signed(v));
    endfunction

    function automatic logic [DW-1:0] ref_sample(input int ph);
        int idx;
        int y;
`ifdef WAVE_LINEAR_INTERP_EN
        int f;
        int a;
        int b;
`endif
        idx = (ph >> 10) & 63;
`ifdef WAVE_LINEAR_INTERP_EN
        f = (ph >> 6) & 15;
        a = sx(tab[idx]);
        b = sx(tab[(idx + 1) & 63]);
        y = a + (((b - a) * f) >>> 4);
`else
        y = sx(tab[idx]);
`endif
        return y[DW-1:0];
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n;
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        #1;
        n = 0;
        while (!wr_ready && n < 20) begin cyc(); n++; end
        check("wr_ready before write", wr_ready, 1);
        cyc();
        wr_valid = 1'b0;
        check("write ram_load", ram_load, 1);
        check("write ram_sel", ram_sel, a);
        check("write ram_in", ram_in, d);
        check("write wr_ready low", wr_ready, 0);
        tab[a] = d;
        cyc();
        check("write ram_load one cycle", ram_load, 0);
    endtask

    task automatic do_tick(input int hold, input string tag);
        logic [DW-1:0] exp;
        int            n;
        exp       = ref_sample(phase_m);
        phase_m   = (phase_m + inc_m) & 16'hFFFF;
        phase_inc = inc_m[PW-1:0];
        smp_ready = 1'b0;
        sample_tick = 1'b1;
        cyc();
        sample_tick = 1'b0;
        n = 1;
        while (!smp_valid && n < 20) begin cyc(); n++; end
        check({tag, " valid"}, smp_valid, 1);
        check({tag, " latency"}, n, LAT);
        check({tag, " data"}, smp_data, exp);
        for (int i = 0; i < hold; i++) begin
            cyc();
            check({tag, " held data"}, smp_data, exp);
        end
        last_data = smp_data;
        smp_ready = 1'b1;
        cyc();
        smp_ready = 1'b0;
        check({tag, " valid dropped"}, smp_valid, 0);
    endtask

    initial begin
        logic [DW-1:0] e1;
        logic [DW-1:0] e2;
        logic [DW-1:0] wd;
        int            n;
        total = 0; passed = 0; failed = 0;
        for (int i = 0; i < 64; i++) begin mem[i] = '0; tab[i] = '0; end
        rst_n = 1'b0; enable = 1'b1; phase_inc = '0; sample_tick = 1'b0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0; smp_ready = 1'b0;
        phase_m = 0; inc_m = 0; last_data = '0;

        // Reset state.
        cyc(); cyc();
        check("rst ram_load", ram_load, 0);
        check("rst ram_in", ram_in, 0);
        check("rst ram_sel", ram_sel, 0);
        check("rst smp_data", smp_data, 0);
        check("rst smp_valid", smp_valid, 0);
        check("rst overrun", overrun, 0);
        check("rst wr_ready", wr_ready, 0);
        rst_n = 1'b1;
        cyc();
        check("wr_ready after release", wr_ready, 1);

        // Single write.
        host_write(6'd5, 20'h12345);

        // Ramp table and 66 ticks with wrap.
        for (int k = 0; k < 64; k++) host_write(k[AW-1:0], DW'(k * 16));
        inc_m = 32'h0400;
        for (int k = 0; k < 66; k++) do_tick(0, "ramp");
        check("ramp wrap last", last_data, 20'd16);

        // Backpressure: held sample, pending tick, dropped tick with overrun.
        e1 = ref_sample(phase_m); phase_m = (phase_m + inc_m) & 16'hFFFF;
        e2 = ref_sample(phase_m); phase_m = (phase_m + inc_m) & 16'hFFFF;
        sample_tick = 1'b1; cyc(); sample_tick = 1'b0;
        n = 0;
        while (!smp_valid && n < 20) begin cyc(); n++; end
        check("ovr first valid", smp_valid, 1);
        check("ovr first data", smp_data, e1);
        sample_tick = 1'b1; cyc(); sample_tick = 1'b0;
        check("ovr second no overrun", overrun, 0);
        cyc();
        sample_tick = 1'b1; cyc(); sample_tick = 1'b0;
        check("ovr third overrun", overrun, 1);
        check("ovr held data", smp_data, e1);
        cyc();
        check("ovr pulse one cycle", overrun, 0);
        smp_ready = 1'b1; cyc(); smp_ready = 1'b0;
        n = 0;
        while (!smp_valid && n < 20) begin cyc(); n++; end
        check("ovr second valid", smp_valid, 1);
        check("ovr second data", smp_data, e2);
        smp_ready = 1'b1; cyc(); smp_ready = 1'b0;
        repeat (6) cyc();
        check("ovr no third sample", smp_valid, 0);

        // Write and tick together: read wins, write waits for the handshake.
        e1 = ref_sample(phase_m); phase_m = (phase_m + inc_m) & 16'hFFFF;
        wd = DW'($urandom);
        wr_valid = 1'b1; wr_addr = 6'd7; wr_data = wd; sample_tick = 1'b1;
        #1;
        check("collide wr_ready low", wr_ready, 0);
        cyc(); sample_tick = 1'b0;
        check("collide no load", ram_load, 0);
        n = 0;
        while (!smp_valid && n < 20) begin cyc(); n++; end
        check("collide valid", smp_valid, 1);
        check("collide data", smp_data, e1);
        cyc();
        check("collide stall wr_ready", wr_ready, 0);
        check("collide stall load", ram_load, 0);
        smp_ready = 1'b1; cyc(); smp_ready = 1'b0;
        check("collide wr_ready after", wr_ready, 1);
        cyc(); wr_valid = 1'b0;
        check("collide load", ram_load, 1);
        check("collide ram_sel", ram_sel, 7);
        check("collide ram_in", ram_in, wd);
        tab[7] = wd;
        cyc();

        // Random table contents, step and backpressure.
        for (int k = 0; k < 20; k++) host_write(AW'($urandom_range(0, 63)), DW'($urandom));
        inc_m = int'($urandom_range(1, 65535));
        for (int k = 0; k < 30; k++) do_tick($urandom_range(0, 3), "rand");

        // enable=0: ticks ignored.
        enable = 1'b0;
        sample_tick = 1'b1; cyc(); sample_tick = 1'b0;
        repeat (5) cyc();
        check("disabled no sample", smp_valid, 0);
        check("disabled wr_ready", wr_ready, 1);
        enable = 1'b1;
        cyc();
        check("disabled no overrun", overrun, 0);

        // Reset mid-read aborts and clears phase.
        sample_tick = 1'b1; cyc(); sample_tick = 1'b0;
        rst_n = 1'b0; cyc();
        check("abort smp_valid", smp_valid, 0);
        check("abort ram_sel", ram_sel, 0);
        check("abort ram_load", ram_load, 0);
        rst_n = 1'b1; phase_m = 0;
        cyc();
        check("abort wr_ready", wr_ready, 1);

        // Interpolation edge cases (exact values with the feature).
        host_write(6'd0, 20'h00000);
        host_write(6'd1, 20'h00100);
        host_write(6'd63, 20'hFFF00);
        inc_m = 32'h0200;
        do_tick(0, "interp p0");
        do_tick(0, "interp p200");
`ifdef WAVE_LINEAR_INTERP_EN
        check("interp mid", last_data, 20'h00080);
`endif
        inc_m = 32'hFA00;
        do_tick(0, "interp p400");
        do_tick(0, "interp pFE00");
`ifdef WAVE_LINEAR_INTERP_EN
        check("interp wrap", last_data, 20'hFFF80);
`else
        check("index 63 sample", last_data, 20'hFFF00);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
